data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Responder (memory) end of the CPU data SRAM interface: accepts `data_sram_en/we/addr/wdata` from the pipeline's EX stage and returns `data_sram_rdata` one cycle later, as the MEM stage expects. It is backed by a word RAM, plus a small MMIO window holding an LED register, a free-running timer and a scratch register. It sits outside `mycpu_top` in the SoC/testbench, alongside the instruction-side memory.

## Interface

Parameters:
- `ADDR_W`, default 10: RAM word-index width. RAM holds 2^ADDR_W 32-bit words.
- `MMIO_HI`, default 16'hbfaf: value of `addr[31:16]` that selects the MMIO window.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `data_sram_en`  in  1  access request this cycle.
- `data_sram_we`  in  4  byte write enables; bit i covers `wdata[8i+7:8i]`; 0 means read.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  write data, byte lanes aligned to the word.
- `data_sram_rdata`  out  32  registered read data.
- `led_out`  out  16  current LED register.
- `timer_out`  out  32  current timer value.

## Operation

- **Decode, per request:**
  - If `addr[31:16]==MMIO_HI`, the request is MMIO and `addr[15:0]` selects the register.
  - Otherwise the request is RAM at word index `addr[ADDR_W+1:2]`. Upper bits are ignored, so the RAM aliases.
- **MMIO map:**
  - 0x0000 LED: RW. Only bits [15:0] are stored; byte lanes 0–1 are writable. Reads return {16'b0, led}.
  - 0x0004 TIMER: RW.
  - 0x0008 SCRATCH: RW, 32 bits, byte-enabled.
  - Any other offset reads 0; writes to it are dropped.
- **Timer:**
  - Increments by 1 every cycle (wraps 0xffffffff→0) except in a cycle with an MMIO write to 0x0004.
  - On such a write it loads the merged value: enabled bytes take `wdata`, other bytes keep the current value. There is no increment that cycle.
- **Writes** (`en=1`, `we!=0`): only the enabled byte lanes of the target word or register change, at the clock edge.
- **Reads are read-first:** in every cycle with `en=1` (including writes), `rdata` is loaded with the target's value *before* that edge's update.
  - The timer read returns the pre-increment value.
  - A write cycle therefore returns the old contents; the CPU ignores `rdata` for stores.
- **Idle** (`en=0`): `rdata` holds its previous value. No state changes except timer counting.
- `we!=0` with `en=0` is ignored.

## Timing

- **Read latency is 1 cycle:** a request sampled at edge N presents `rdata` after edge N, valid throughout cycle N+1.
- **Throughput:** one access per cycle, back-to-back, with no stall or ready signal.
- **Back-to-back write then read of the same word:** the read at edge N+1 returns the data written at edge N, because the write has completed before the read-first sample.
- **Reset values while `resetn=0`** (asynchronous assertion; deassertion takes effect at the next edge):
  - `data_sram_rdata` = 0
  - `led_out` = 0
  - `timer_out` = 0
  - SCRATCH = 0
- **RAM is not reset.** Contents are undefined until written.
- **Timer after reset:** it reads 0 on the first edge after deassertion and counts from there.
- **Reset asserted mid-access:** the pending `rdata` is forced to 0. A write sampled on the same edge that reset asserts is lost.
- `led_out` and `timer_out` are direct register outputs with no extra latency.

## Test plan

- **Reset:**
  - Stimulus: hold `resetn=0` 3 cycles with random inputs.
  - Required: `rdata`=0, `led_out`=0, `timer_out`=0.
  - Then release and idle 5 cycles: MMIO read of 0x0004 returns a value consistent with `timer_out` at the sample edge.
- **RAM byte writes:**
  - Stimulus: write 0x11223344 to 0x1c000010 with we=4'b1111, then 0xaaaaaaaa with we=4'b0101, then read.
  - Required: read returns 0x11aa33aa one cycle after the request; the write cycles return the old word.
- **Back-to-back and aliasing:**
  - Stimulus: write 0xdeadbeef to 0x00000004, read 0x00001004 in the next cycle (ADDR_W=10).
  - Required: read returns 0xdeadbeef.
- **MMIO:**
  - Stimulus: write 0x1234abcd to 0xbfaf0000 (we=4'b1111), then read it.
  - Required: `led_out`=0xabcd; read returns 0x0000abcd.
  - Stimulus: read 0xbfaf0010.
  - Required: returns 0.
- **Timer load:**
  - Stimulus: write 0xffffffff to 0xbfaf0004 at edge N.
  - Required: `timer_out`=0xffffffff after edge N, 0x00000000 after edge N+1. A read sampled at edge N+1 returns 0xffffffff.
- **Idle hold and reset mid-access:**
  - Stimulus: read SCRATCH after writing 0xcafef00d, then drop `en` for 4 cycles.
  - Required: `rdata` stays 0xcafef00d.
  - Stimulus: assert `resetn=0` asynchronously.
  - Required: `rdata` becomes 0 immediately; SCRATCH reads 0 after reset is released.

Source files
------------

// File: rtl/data_sram_responder_if.sv
// CPU data SRAM bus: the pipeline drives the request, the memory returns registered read data.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side memory: word RAM plus LED/timer/scratch MMIO window, read-first, 1-cycle read latency.
// Accepts one access every cycle; there is no backpressure.
module data_sram_responder #(
  parameter int          ADDR_W  = 10,
  parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
  input  logic                        clk,
  input  logic                        resetn,
  data_sram_responder_if.slave        bus,
  output logic [15:0]                 led_out,
  output logic [31:0]                 timer_out
);

  localparam logic [15:0] OFF_LED = 16'h0000;
  localparam logic [15:0] OFF_TMR = 16'h0004;
  localparam logic [15:0] OFF_SCR = 16'h0008;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [15:0]       led_q, led_d;
  logic              is_mmio, wr, ram_wr;
  logic [15:0]       off;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_val;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  assign is_mmio = (bus.data_sram_addr[31:16] == MMIO_HI);
  assign off     = bus.data_sram_addr[15:0];
  assign idx     = bus.data_sram_addr[ADDR_W+1:2];
  assign wr      = bus.data_sram_en && (bus.data_sram_we != 4'b0000);
  // RAM has no reset, so gate its write enable to drop a store sampled while reset is held.
  assign ram_wr  = wr && !is_mmio && resetn;

  always_comb begin
    rd_val    = 32'h0;
    led_d     = led_q;
    scratch_d = scratch_q;
    timer_d   = timer_q + 32'h1;
    if (is_mmio) begin
      case (off)
        OFF_LED: rd_val = {16'h0, led_q};
        OFF_TMR: rd_val = timer_q;
        OFF_SCR: rd_val = scratch_q;
        default: rd_val = 32'h0;
      endcase
    end else begin
      rd_val = mem[idx];
    end
    rdata_d = bus.data_sram_en ? rd_val : rdata_q;
    if (wr && is_mmio) begin
      if (off == OFF_LED) begin
        led_d[7:0]  = bus.data_sram_we[0] ? bus.data_sram_wdata[7:0]  : led_q[7:0];
        led_d[15:8] = bus.data_sram_we[1] ? bus.data_sram_wdata[15:8] : led_q[15:8];
      end
      if (off == OFF_TMR) timer_d = merge(timer_q, bus.data_sram_wdata, bus.data_sram_we);
      if (off == OFF_SCR) scratch_d = merge(scratch_q, bus.data_sram_wdata, bus.data_sram_we);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      timer_q   <= 32'h0;
      scratch_q <= 32'h0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_we[i]) mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign led_out             = led_q;
  assign timer_out           = timer_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: table of request vectors plus hand-written reset/timer sequences.
module tb_data_sram_responder;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] led_out;
  logic [31:0] timer_out;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [31:0] tmr_m = 32'h0;
  logic [15:0] led_m = 16'h0;
  vec_t        tbl[22];

  data_sram_responder_if bus ();

  data_sram_responder #(.ADDR_W(10), .MMIO_HI(16'hbfaf)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .led_out   (led_out),
    .timer_out (timer_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Called just after a falling edge: drive, clock, update models, then compare at the next fall.
  task automatic cycle(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd);
    exp_t e;
    bus.data_sram_en    = en;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wd;
    sb.push_back('{chk_rd, exp_rd});
    @(posedge clk);
    if (en && we != 4'h0 && addr[31:16] == 16'hbfaf && addr[15:0] == 16'h0004)
      tmr_m = bmerge(tmr_m, wd, we);
    else
      tmr_m = tmr_m + 32'h1;
    if (en && we != 4'h0 && addr[31:16] == 16'hbfaf && addr[15:0] == 16'h0000)
      led_m = bmerge({16'h0, led_m}, wd, {2'b00, we[1:0]}) & 32'h0000ffff;
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk) check($sformatf("rdata@%08h", addr), bus.data_sram_rdata, e.val);
    check("timer_out", timer_out, tmr_m);
    check("led_out", {16'h0, led_out}, {16'h0, led_m});
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'hf, 32'h1c000010, 32'h11223344, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 4'h5, 32'h1c000010, 32'haaaaaaaa, 1'b1, 32'h11223344};
    tbl[2]  = '{1'b1, 4'h0, 32'h1c000010, 32'h0,        1'b1, 32'h11aa33aa};
    tbl[3]  = '{1'b1, 4'hf, 32'h00000004, 32'hdeadbeef, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 4'h0, 32'h00001004, 32'h0,        1'b1, 32'hdeadbeef};
    tbl[5]  = '{1'b1, 4'hf, 32'hbfaf0000, 32'h1234abcd, 1'b1, 32'h00000000};
    tbl[6]  = '{1'b1, 4'h0, 32'hbfaf0000, 32'h0,        1'b1, 32'h0000abcd};
    tbl[7]  = '{1'b1, 4'hc, 32'hbfaf0000, 32'hffffffff, 1'b1, 32'h0000abcd};
    tbl[8]  = '{1'b1, 4'h0, 32'hbfaf0000, 32'h0,        1'b1, 32'h0000abcd};
    tbl[9]  = '{1'b1, 4'h0, 32'hbfaf0010, 32'h0,        1'b1, 32'h00000000};
    tbl[10] = '{1'b1, 4'hf, 32'hbfaf0010, 32'hffffffff, 1'b1, 32'h00000000};
    tbl[11] = '{1'b1, 4'h0, 32'hbfaf0010, 32'h0,        1'b1, 32'h00000000};
    tbl[12] = '{1'b0, 4'hf, 32'h1c000010, 32'h55555555, 1'b1, 32'h00000000};
    tbl[13] = '{1'b1, 4'h0, 32'h1c000010, 32'h0,        1'b1, 32'h11aa33aa};
    tbl[14] = '{1'b1, 4'hf, 32'hbfaf0008, 32'hcafef00d, 1'b1, 32'h00000000};
    tbl[15] = '{1'b1, 4'h1, 32'hbfaf0008, 32'h000000ee, 1'b1, 32'hcafef00d};
    tbl[16] = '{1'b1, 4'hf, 32'hbfaf0008, 32'hcafef00d, 1'b1, 32'hcafef0ee};
    tbl[17] = '{1'b1, 4'h0, 32'hbfaf0008, 32'h0,        1'b1, 32'hcafef00d};
    tbl[18] = '{1'b0, 4'hf, 32'hbfaf0008, 32'h0,        1'b1, 32'hcafef00d};
    tbl[19] = '{1'b0, 4'h0, 32'h00000004, 32'h0,        1'b1, 32'hcafef00d};
    tbl[20] = '{1'b0, 4'h3, 32'hbfaf0000, 32'h0,        1'b1, 32'hcafef00d};
    tbl[21] = '{1'b0, 4'h0, 32'hbfaf0004, 32'h0,        1'b1, 32'hcafef00d};

    for (int i = 0; i < 3; i++) begin
      bus.data_sram_en    = 1'($urandom);
      bus.data_sram_we    = 4'($urandom);
      bus.data_sram_addr  = $urandom;
      bus.data_sram_wdata = $urandom;
      @(negedge clk);
      check("reset rdata", bus.data_sram_rdata, 32'h0);
      check("reset led", {16'h0, led_out}, 32'h0);
      check("reset timer", timer_out, 32'h0);
    end
    resetn = 1'b1;
    tmr_m  = 32'h0;
    led_m  = 16'h0;

    for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0);
    cycle(1'b1, 4'h0, 32'hbfaf0004, 32'h0, 1'b1, tmr_m);

    cycle(1'b1, 4'hf, 32'hbfaf0004, 32'hffffffff, 1'b1, tmr_m);
    check("timer loaded", timer_out, 32'hffffffff);
    cycle(1'b1, 4'h0, 32'hbfaf0004, 32'h0, 1'b1, 32'hffffffff);
    check("timer wrapped", timer_out, 32'h00000000);
    cycle(1'b1, 4'h2, 32'hbfaf0004, 32'h0000ab00, 1'b1, tmr_m);
    cycle(1'b1, 4'h0, 32'hbfaf0004, 32'h0, 1'b1, 32'h0000ab00);

    for (int i = 0; i < 22; i++)
      cycle(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].chk, tbl[i].exp_rd);

    // Asynchronous reset in the middle of a pending read, with a scratch write held during reset.
    bus.data_sram_en   = 1'b1;
    bus.data_sram_we   = 4'h0;
    bus.data_sram_addr = 32'hbfaf0008;
    #2 resetn = 1'b0;
    #1;
    check("async rdata", bus.data_sram_rdata, 32'h0);
    check("async led", {16'h0, led_out}, 32'h0);
    check("async timer", timer_out, 32'h0);
    bus.data_sram_we    = 4'hf;
    bus.data_sram_wdata = 32'h12345678;
    @(negedge clk);
    check("held rdata", bus.data_sram_rdata, 32'h0);
    resetn = 1'b1;
    tmr_m  = 32'h0;
    led_m  = 16'h0;
    cycle(1'b1, 4'h0, 32'hbfaf0008, 32'h0, 1'b1, 32'h00000000);
    cycle(1'b1, 4'h0, 32'hbfaf0000, 32'h0, 1'b1, 32'h00000000);
    cycle(1'b1, 4'h0, 32'h1c000010, 32'h0, 1'b1, 32'h11aa33aa);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
